// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern-detection controller.
package seq_det_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W       = $clog2(MAX_LEN_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // A length of 0 means a single-bit pattern; anything longer than the
    // history can hold is cut down to the full history depth.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Bit matcher: history shift register, fill counter and masked comparator.
// The match output is combinational so the controller can raise z in the
// same cycle as the completing bit.
module seq_det_match #(
    parameter int MAX_LEN = 8,
    parameter int LW      = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LW-1:0]      len,
    input  logic               overlap,
    output logic               match
);

    // Only MAX_LEN-1 past bits are needed; the current bit completes the window.
    logic [MAX_LEN-2:0] hist;
    logic [LW-1:0]      fill;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;

    assign window = {hist, x};

    // Select the low len bits of the window for comparison.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
    end

    // fill counts bits seen since the last clear; len-1 of them plus the
    // current bit must be present before a match can complete.
    assign match = en && (fill >= len - LW'(1)) &&
                   (((window ^ pattern) & mask) == '0);

    // Shift history on each qualified bit; a non-overlapping match restarts fill.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window[MAX_LEN-2:0];
            if (match && !overlap)
                fill <= '0;
            else if (fill != LW'(MAX_LEN))
                fill <= fill + LW'(1);
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detection controller: config registers,
// IDLE/RUN/DONE sequencing and hit counting around the bit matcher.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [$clog2(MAX_LEN):0]   cfg_len,
    input  logic                       cfg_overlap,
    input  logic [CNT_W-1:0]           cfg_target,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       x_valid,
    input  logic                       x,
    output logic                       z,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           hit_cnt
);

    localparam int LW = $clog2(MAX_LEN) + 1;

    seq_state_t         state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic               match;
    logic [CNT_W-1:0]   hit_nxt;

    // History is held clear outside RUN, so every start begins from empty.
    seq_det_match #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .clr     (state != RUN),
        .en      ((state == RUN) && x_valid),
        .x       (x),
        .pattern (pat_q),
        .len     (len_q),
        .overlap (ovl_q),
        .match   (match)
    );

    assign z = match && !abort && !reset;

    // Unlimited mode saturates the counter; with a target it stops at DONE.
    always_comb begin
        hit_nxt = hit_cnt + CNT_W'(1);
        if (tgt_q == '0 && hit_cnt == '1)
            hit_nxt = hit_cnt;
    end

    // Configuration is only writable while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q <= '0;
            len_q <= LW'(1);
            ovl_q <= 1'b1;
            tgt_q <= '0;
        end else if (cfg_we && state == IDLE) begin
            pat_q <= cfg_pattern;
            len_q <= LW'(clamp_len(32'(cfg_len), 32'(MAX_LEN)));
            ovl_q <= cfg_overlap;
            tgt_q <= cfg_target;
        end
    end

    // Control FSM with registered status; abort outranks match and start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        hit_cnt <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (match) begin
                        hit_cnt <= hit_nxt;
                        if (tgt_q != '0 && hit_nxt == tgt_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        hit_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_seq_det_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             reset, cfg_we, cfg_overlap, start, abort, x_valid, x;
    logic [7:0]       cfg_pattern;
    logic [3:0]       cfg_len;
    logic [7:0]       cfg_target;
    logic             z, busy, done;
    logic [7:0]       hit_cnt;

    always #5 clk = ~clk;

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .abort(abort), .x_valid(x_valid), .x(x),
        .z(z), .busy(busy), .done(done), .hit_cnt(hit_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 run, 2 done; m_q holds usable bits, oldest first.
    int       m_state;
    logic [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_tgt;
    int       m_cnt;
    bit       m_q[$];
    bit       obs_z, exp_z;

    function automatic bit model_z(bit xv, bit xb, bit ab, bit rst);
        bit seq[$];
        if (rst || ab || m_state != 1 || !xv) return 1'b0;
        seq = m_q;
        seq.push_back(xb);
        if (seq.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (seq[seq.size() - 1 - k] != m_pat[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit hit;
        if (reset) begin
            m_state = 0; m_pat = 8'd0; m_len = 1; m_ovl = 1'b1; m_tgt = 0; m_cnt = 0;
            m_q.delete();
            return;
        end
        hit = model_z(x_valid, x, 1'b0, 1'b0);
        case (m_state)
            0: begin
                if (cfg_we) begin
                    m_pat = cfg_pattern;
                    m_len = (cfg_len == 0) ? 1 : ((cfg_len > MAX_LEN) ? MAX_LEN : int'(cfg_len));
                    m_ovl = cfg_overlap;
                    m_tgt = int'(cfg_target);
                end
                if (start && !abort) begin m_state = 1; m_cnt = 0; m_q.delete(); end
            end
            1: begin
                if (abort) m_state = 0;
                else if (x_valid) begin
                    m_q.push_back(x);
                    if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
                    if (hit) begin
                        if (!(m_tgt == 0 && m_cnt == 255)) m_cnt++;
                        if (!m_ovl) m_q.delete();
                        if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
                    end
                end
            end
            default: begin
                if (abort) m_state = 0;
                else if (start) begin m_state = 1; m_cnt = 0; m_q.delete(); end
            end
        endcase
    endtask

    task automatic set_cfg(logic [7:0] pat, logic [3:0] len, bit ovl, logic [7:0] tgt);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
    endtask

    // One clock: drive at negedge, sample z before the edge, update model after.
    task automatic step(bit we, bit st, bit ab, bit xv, bit xb, bit rst);
        @(negedge clk);
        cfg_we = we; start = st; abort = ab; x_valid = xv; x = xb; reset = rst;
        #1;
        obs_z = z;
        exp_z = model_z(xv, xb, ab, rst);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_stream(bit we, logic [7:0] s, int n, output logic [7:0] zm);
        zm = 8'd0;
        for (int i = 0; i < n; i++) begin
            step(we, 1'b0, 1'b0, 1'b1, s[i], 1'b0);
            zm[i] = obs_z;
        end
    endtask

    task automatic test_reset();
        set_cfg(8'd0, 4'd0, 1'b0, 8'd0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 1);
        checks++; if (obs_z !== 1'b0) begin failures++; $display("FAIL reset_z got=%b exp=0", obs_z); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_status busy=%b done=%b exp=0/0", busy, done); end
        checks++; if (hit_cnt !== 8'd0) begin failures++; $display("FAIL reset_hit got=%0d exp=0", hit_cnt); end
    endtask

    // Stream 1,0,1,0,1,1,0,1 packed with bit i = stream element i+1.
    localparam logic [7:0] STREAM = 8'b1011_0101;

    task automatic test_overlap();
        logic [7:0] zm;
        set_cfg(8'b101, 4'd3, 1'b1, 8'd0);
        step(1, 1, 0, 1, 1, 0);
        checks++; if (busy !== 1'b1 || hit_cnt !== 8'd0) begin failures++; $display("FAIL start_busy busy=%b hit=%0d exp=1/0", busy, hit_cnt); end
        run_stream(0, STREAM, 8, zm);
        checks++; if (zm !== 8'h94) begin failures++; $display("FAIL overlap_z got=%h exp=94", zm); end
        checks++; if (hit_cnt !== 8'd3) begin failures++; $display("FAIL overlap_hit got=%0d exp=3", hit_cnt); end
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_nonoverlap();
        logic [7:0] zm;
        set_cfg(8'b101, 4'd3, 1'b0, 8'd0);
        step(1, 1, 0, 0, 0, 0);
        run_stream(0, STREAM, 8, zm);
        checks++; if (zm !== 8'h84) begin failures++; $display("FAIL nonoverlap_z got=%h exp=84", zm); end
        checks++; if (hit_cnt !== 8'd2) begin failures++; $display("FAIL nonoverlap_hit got=%0d exp=2", hit_cnt); end
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_target();
        logic [7:0] zm;
        set_cfg(8'b101, 4'd3, 1'b1, 8'd2);
        step(1, 1, 0, 0, 0, 0);
        run_stream(0, STREAM, 5, zm);
        checks++; if (zm !== 8'h14) begin failures++; $display("FAIL target_z got=%h exp=14", zm); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL target_done done=%b busy=%b exp=1/0", done, busy); end
        run_stream(0, 8'b0000_0101, 3, zm);
        checks++; if (zm !== 8'h00) begin failures++; $display("FAIL done_no_z got=%h exp=00", zm); end
        checks++; if (hit_cnt !== 8'd2 || done !== 1'b1) begin failures++; $display("FAIL done_frozen hit=%0d done=%b exp=2/1", hit_cnt, done); end
        step(0, 1, 0, 0, 0, 0);
        checks++; if (hit_cnt !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL restart hit=%0d busy=%b done=%b exp=0/1/0", hit_cnt, busy, done); end
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_valid_gap();
        int zc = 0;
        set_cfg(8'b101, 4'd3, 1'b1, 8'd0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0); zc += int'(obs_z);
        step(0, 0, 0, 1, 0, 0); zc += int'(obs_z);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1'($urandom), 0); zc += int'(obs_z);
        end
        step(0, 0, 0, 1, 1, 0); zc += int'(obs_z);
        checks++; if (obs_z !== 1'b1 || zc != 1) begin failures++; $display("FAIL gap_z last=%b count=%0d exp=1/1", obs_z, zc); end
        checks++; if (hit_cnt !== 8'd1) begin failures++; $display("FAIL gap_hit got=%0d exp=1", hit_cnt); end
    endtask

    // Continues from the gap test: still running with one hit recorded.
    task automatic test_abort();
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1, 0);
        checks++; if (obs_z !== 1'b0) begin failures++; $display("FAIL abort_z got=%b exp=0", obs_z); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || hit_cnt !== 8'd1) begin failures++; $display("FAIL abort_idle busy=%b done=%b hit=%0d exp=0/0/1", busy, done, hit_cnt); end
    endtask

    task automatic test_cfg_in_run();
        logic [7:0] zm;
        set_cfg(8'b101, 4'd3, 1'b1, 8'd0);
        step(1, 1, 0, 0, 0, 0);
        set_cfg(8'b111, 4'd3, 1'b1, 8'd0);
        run_stream(1, 8'b0001_0111, 5, zm);
        checks++; if (zm !== 8'h10) begin failures++; $display("FAIL cfg_run_z got=%h exp=10", zm); end
        checks++; if (hit_cnt !== 8'd1) begin failures++; $display("FAIL cfg_run_hit got=%0d exp=1", hit_cnt); end
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_len0();
        logic [7:0] zm;
        set_cfg(8'b1, 4'd0, 1'b1, 8'd0);
        step(1, 1, 0, 0, 0, 0);
        run_stream(0, 8'b0000_1101, 5, zm);
        checks++; if (zm !== 8'h0d) begin failures++; $display("FAIL len0_z got=%h exp=0d", zm); end
        checks++; if (hit_cnt !== 8'd3) begin failures++; $display("FAIL len0_hit got=%0d exp=3", hit_cnt); end
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] zm;
        set_cfg(8'b101, 4'd3, 1'b1, 8'd0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1);
        checks++; if (obs_z !== 1'b0) begin failures++; $display("FAIL rst_run_z got=%b exp=0", obs_z); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || hit_cnt !== 8'd0) begin failures++; $display("FAIL rst_run_state busy=%b done=%b hit=%0d exp=0/0/0", busy, done, hit_cnt); end
        // Default config after reset: single-bit pattern 0, overlapping.
        step(0, 1, 0, 0, 0, 0);
        run_stream(0, 8'b0000_0010, 3, zm);
        checks++; if (zm !== 8'h05 || hit_cnt !== 8'd2) begin failures++; $display("FAIL default_cfg z=%h hit=%0d exp=05/2", zm, hit_cnt); end
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic [3:0] len;
            len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
            set_cfg(8'($urandom), len, 1'($urandom), 8'($urandom_range(0, 4)));
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 149) == 0);
            checks++; if (obs_z !== exp_z) begin failures++; $display("FAIL rand_z cyc=%0d got=%b exp=%b", n, obs_z, exp_z); end
            checks++; if (busy !== (m_state == 1) || done !== (m_state == 2)) begin failures++; $display("FAIL rand_state cyc=%0d busy=%b done=%b exp_state=%0d", n, busy, done, m_state); end
            checks++; if (hit_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL rand_hit cyc=%0d got=%0d exp=%0d", n, hit_cnt, m_cnt); end
        end
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; start = 1'b0; abort = 1'b0; x_valid = 1'b0; x = 1'b0;
        cfg_pattern = 8'd0; cfg_len = 4'd0; cfg_overlap = 1'b0; cfg_target = 8'd0;
        m_state = 0; m_pat = 8'd0; m_len = 1; m_ovl = 1'b1; m_tgt = 0; m_cnt = 0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_target();
        test_valid_gap();
        test_abort();
        test_cfg_in_run();
        test_len0();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial pattern-detection controller built around a Mealy-style bit matcher. It holds a run-time pattern of up to `MAX_LEN` bits, arms and disarms detection, and applies overlapping or non-overlapping match rules. It counts hits and stops after a programmed number of matches. It sits between a serial bit source and the control/status logic that previously drove a fixed-pattern detector directly.

## Interface
Parameters:
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: width of the hit counter and the target value.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `cfg_we`, in, 1: configuration write strobe; accepted only in IDLE.
- `cfg_pattern`, in, MAX_LEN: pattern; `pattern[len-1]` is the oldest bit, `pattern[0]` the newest.
- `cfg_len`, in, $clog2(MAX_LEN)+1: pattern length; 0 is treated as 1, values above MAX_LEN clamp to MAX_LEN.
- `cfg_overlap`, in, 1: 1 selects overlapping matches; 0 clears history after each match.
- `cfg_target`, in, CNT_W: number of hits before DONE; 0 means unlimited.
- `start`, in, 1: arm detection (IDLE or DONE → RUN).
- `abort`, in, 1: return to IDLE from any state.
- `x_valid`, in, 1: qualifies `x`.
- `x`, in, 1: serial data bit.
- `z`, out, 1: Mealy match pulse, combinational in the cycle of the completing bit.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `hit_cnt`, out, CNT_W: matches since last start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `cfg_we` latches pattern, len (after clamp), overlap and target.
  - `start` → RUN; clears `hit_cnt`, history and fill count.
  - `cfg_we` and `start` in the same cycle: config latched, then start takes effect using the new config.
- RUN:
  - Each `x_valid` cycle shifts `x` into the history register.
  - Fill count increments, saturating at MAX_LEN.
  - Cycles with `x_valid` low change nothing, including `z` and the history.
- Match is asserted when all of these hold: state is RUN, `x_valid=1`, fill ≥ len-1, and the low len bits of {history, x} equal the low len bits of `cfg_pattern`.
- `z` equals match, gated low when `abort` is high.
- On match:
  - `hit_cnt` increments; in unlimited mode it saturates at all-ones.
  - If `cfg_overlap=0`, fill count clears so the completing bit is not reused.
  - If target ≠ 0 and `hit_cnt+1 == target`, go to DONE.
- DONE:
  - `done` holds and `hit_cnt` is frozen.
  - `z` is low and `x` is ignored.
  - `start` → RUN with counters cleared.
- `abort` → IDLE from RUN or DONE. It has priority over match and start. `hit_cnt` is retained.
- `cfg_we` outside IDLE is ignored; the active configuration is unchanged.

## Timing
- Reset values: state IDLE, `z=0`, `busy=0`, `done=0`, `hit_cnt=0`, history/fill=0. Config registers reset to pattern 0, len 1, overlap 1, target 0.
- `z` has zero latency: same cycle as the completing `x`.
- `hit_cnt`, `busy` and `done` update on the following edge.
- `start` at edge N: `busy=1` after N, and the first bit is sampled at edge N+1 (bits presented in the start cycle are not used).
- Reset during RUN: IDLE on the next edge, with no `z` in that cycle.

## Structure
- Package `seq_det_pkg`:
  - state enum `seq_state_t` (IDLE/RUN/DONE);
  - localparam `LEN_W = $clog2(MAX_LEN)+1`;
  - a length-clamp function.
- Sub-module `seq_det_match`: history shift register, fill counter and masked comparator; outputs combinational match.
- The top level holds config registers, the FSM and the hit counter.

## Test plan
- Overlap, pattern 3'b101, len 3, target 0, stream 1,0,1,0,1,1,0,1 → `z` on bits 3, 5 and 8; `hit_cnt=3`.
- Same stream with `cfg_overlap=0` → `z` on bits 3 and 8 only; `hit_cnt=2`.
- Overlap with target 2, same stream → `done=1` after bit 5; no `z` on bit 8; `hit_cnt=2`. A subsequent `start` clears the count to 0.
- `x_valid` low for 3 cycles between bits 2 and 3 of 1,0,1 → a single `z` on bit 3. `abort` asserted together with a completing bit → `z=0`, IDLE next cycle.
- `cfg_we` in RUN with pattern 3'b111 → ignored; 101 still detected. `cfg_len=0`, pattern 1 → every valid 1 gives `z`.
- `reset` asserted mid-RUN → all outputs at reset values the next cycle; a later `start` works with the default config.
